// File: rtl/fpga2hps_arb_pkg.sv
// Shared types and constants for the FPGA-to-HPS PIO arbiter family.
package fpga2hps_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned WORD_COUNT_W = 16;

  // Index width needed to address n requesters; never narrower than 1 bit.
  function automatic int unsigned tag_w_for(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid request after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [TAG_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [TAG_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = TAG_W'((32'(ptr) + k) % NUM_REQ);
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpga2hps_pio_arbiter.sv
// Round-robin sharing of the 16-bit FPGA-to-HPS PIO port with a seq/ack handshake.
// Optional HPS-ack timeout enabled by defining FPGA2HPS_ARB_TIMEOUT_EN.
module fpga2hps_pio_arbiter
  import fpga2hps_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TAG_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         pio_data,
  output logic [TAG_W-1:0]          pio_tag,
  output logic                      pio_seq,
  input  logic                      hps_ack,
  output logic                      busy,
`ifdef FPGA2HPS_ARB_TIMEOUT_EN
  output logic                      timeout_err,
`endif
  output logic [WORD_COUNT_W-1:0]   word_count
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
    $error("NUM_REQ must be in 2..8");
  end
  if (TAG_W != tag_w_for(NUM_REQ)) begin : g_tag_w_check
    $error("TAG_W must equal clog2(NUM_REQ)");
  end

  arb_state_e                state_q, state_d;
  logic [TAG_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]         pio_data_q, pio_data_d;
  logic [TAG_W-1:0]          pio_tag_q, pio_tag_d;
  logic                      pio_seq_q, pio_seq_d;
  logic                      busy_q, busy_d;
  logic [WORD_COUNT_W-1:0]   word_count_q, word_count_d;
  logic                      ack_meta_q, ack_meta_d;
  logic                      ack_s_q, ack_s_d;

  logic [NUM_REQ-1:0]        grant;
  logic [TAG_W-1:0]          grant_idx;
  logic                      grant_any;

`ifdef FPGA2HPS_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
  logic                      timeout_err_q, timeout_err_d;
  assign timeout_err = timeout_err_q;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    pio_data_d   = pio_data_q;
    pio_tag_d    = pio_tag_q;
    pio_seq_d    = pio_seq_q;
    busy_d       = busy_q;
    word_count_d = word_count_q;
    ack_meta_d   = hps_ack;
    ack_s_d      = ack_meta_q;
    req_ready    = '0;
`ifdef FPGA2HPS_ARB_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      IDLE: begin
        // grant is only ever set on a valid requester, so ready implies transfer
        req_ready = grant;
        if (grant_any) begin
          pio_data_d = req_data[grant_idx*DATA_W +: DATA_W];
          pio_tag_d  = grant_idx;
          pio_seq_d  = ~pio_seq_q;
          busy_d     = 1'b1;
          rr_ptr_d   = grant_idx;
          state_d    = WAIT;
`ifdef FPGA2HPS_ARB_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (ack_s_q == pio_seq_q) begin
          busy_d       = 1'b0;
          word_count_d = word_count_q + WORD_COUNT_W'(1);
          state_d      = IDLE;
        end
`ifdef FPGA2HPS_ARB_TIMEOUT_EN
        else if (to_cnt_q + TO_W'(1) == TO_W'(TIMEOUT_CYCLES)) begin
          // abandon the word; pio_seq stays advanced so the HPS can spot the gap
          busy_d        = 1'b0;
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= TAG_W'(NUM_REQ - 1);
      pio_data_q    <= '0;
      pio_tag_q     <= '0;
      pio_seq_q     <= 1'b0;
      busy_q        <= 1'b0;
      word_count_q  <= '0;
      ack_meta_q    <= 1'b0;
      ack_s_q       <= 1'b0;
`ifdef FPGA2HPS_ARB_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      pio_data_q    <= pio_data_d;
      pio_tag_q     <= pio_tag_d;
      pio_seq_q     <= pio_seq_d;
      busy_q        <= busy_d;
      word_count_q  <= word_count_d;
      ack_meta_q    <= ack_meta_d;
      ack_s_q       <= ack_s_d;
`ifdef FPGA2HPS_ARB_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign pio_data   = pio_data_q;
  assign pio_tag    = pio_tag_q;
  assign pio_seq    = pio_seq_q;
  assign busy       = busy_q;
  assign word_count = word_count_q;

endmodule
